// File: rtl/dual_slope_bcd_ctrl.sv
`default_nettype none
//=============================================================================
// dual_slope_bcd_ctrl : dual-slope ADC sequencer, N-digit BCD counter,
//                       display latch and 7-segment decode.        Rev 1.0
//=============================================================================
module dual_slope_bcd_ctrl #(
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enb,
   input  logic                  cmp,
   input  logic                  hold,
   output logic                  ch_zr,
   output logic                  ch_vm,
   output logic                  ch_ref,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out,
   output logic                  ovr,
   output logic                  valid
);

   localparam logic [4*DIGITS-1:0] c_MAX = {DIGITS{4'd9}};

   typedef enum logic [1:0] {
      ST_AZ    = 2'd0,
      ST_INT   = 2'd1,
      ST_DEINT = 2'd2
   } state_t;

   state_t              state_q;
   logic                cmp_meta_q;
   logic                cmp_s_q;
   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] count_d;
   logic [4*DIGITS-1:0] bcd_q;
   logic                ovr_q;
   logic                valid_q;
   logic                ch_zr_q;
   logic                ch_vm_q;
   logic                ch_ref_q;
   logic                w_max;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // A digit steps only when every lower digit reads 9 (cascaded carry).
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         logic [3:0] w_dig;
         logic       w_inc;
         assign w_dig = count_q[4*k +: 4];
         if (k == 0) begin : g_lsd
            assign w_inc = 1'b1;
         end else begin : g_upper
            assign w_inc = (count_q[4*k-1:0] == c_MAX[4*k-1:0]);
         end
         assign count_d[4*k +: 4] = !w_inc ? w_dig :
                                    (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
         assign seg_out[7*k +: 7] = ovr_q ? 7'b0000001 : seg7(bcd_q[4*k +: 4]);
      end
   endgenerate

   assign w_max = (count_q == c_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_AZ;
         count_q    <= '0;
         bcd_q      <= '0;
         ovr_q      <= 1'b0;
         valid_q    <= 1'b0;
         cmp_meta_q <= 1'b0;
         cmp_s_q    <= 1'b0;
         ch_zr_q    <= 1'b1;
         ch_vm_q    <= 1'b0;
         ch_ref_q   <= 1'b0;
      end else begin
         cmp_meta_q <= cmp;
         cmp_s_q    <= cmp_meta_q;
         valid_q    <= 1'b0;
         if (enb) begin
            case (state_q)
               ST_AZ: begin
                  if (w_max) begin
                     count_q <= '0;
                     state_q <= ST_INT;
                     ch_zr_q <= 1'b0;
                     ch_vm_q <= 1'b1;
                  end else begin
                     count_q <= count_d;
                  end
               end
               ST_INT: begin
                  if (w_max) begin
                     count_q  <= '0;
                     state_q  <= ST_DEINT;
                     ch_vm_q  <= 1'b0;
                     ch_ref_q <= 1'b1;
                  end else begin
                     count_q <= count_d;
                  end
               end
               ST_DEINT: begin
                  // Comparator takes priority, so a crossing at full scale is a valid reading.
                  if (cmp_s_q || w_max) begin
                     if (!hold) begin
                        bcd_q <= cmp_s_q ? count_q : c_MAX;
                        ovr_q <= !cmp_s_q;
                     end
                     valid_q  <= 1'b1;
                     count_q  <= '0;
                     state_q  <= ST_AZ;
                     ch_ref_q <= 1'b0;
                     ch_zr_q  <= 1'b1;
                  end else begin
                     count_q <= count_d;
                  end
               end
               default: begin
                  count_q  <= '0;
                  state_q  <= ST_AZ;
                  ch_zr_q  <= 1'b1;
                  ch_vm_q  <= 1'b0;
                  ch_ref_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ch_zr   = ch_zr_q;
   assign ch_vm   = ch_vm_q;
   assign ch_ref  = ch_ref_q;
   assign bcd_out = bcd_q;
   assign ovr     = ovr_q;
   assign valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_slope_bcd_ctrl.sv
`default_nettype none
//=============================================================================
// tb_dual_slope_bcd_ctrl : self-checking bench for dual_slope_bcd_ctrl (DIGITS=2)
//                          Rev 1.0
//=============================================================================
module tb_dual_slope_bcd_ctrl;

   localparam int DIGITS = 2;
   localparam int FS     = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        enb;
   logic        cmp;
   logic        hold;
   logic        ch_zr;
   logic        ch_vm;
   logic        ch_ref;
   logic [7:0]  bcd_out;
   logic [13:0] seg_out;
   logic        ovr;
   logic        valid;

   int tests = 0;
   int fails = 0;

   dual_slope_bcd_ctrl #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst     (rst),
      .enb     (enb),
      .cmp     (cmp),
      .hold    (hold),
      .ch_zr   (ch_zr),
      .ch_vm   (ch_vm),
      .ch_ref  (ch_ref),
      .bcd_out (bcd_out),
      .seg_out (seg_out),
      .ovr     (ovr),
      .valid   (valid)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:       return 7'b1111110;
         1:       return 7'b0110000;
         2:       return 7'b1101101;
         3:       return 7'b1111001;
         4:       return 7'b0110011;
         5:       return 7'b1011011;
         6:       return 7'b1011111;
         7:       return 7'b1110000;
         8:       return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   function automatic logic [7:0] exp_bcd(input int n);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   function automatic logic [13:0] exp_seg(input int n, input bit ov);
      if (ov) return {7'b0000001, 7'b0000001};
      return {seg_of(n / 10), seg_of(n % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one conversion whose comparator crossing lands at count n (n>=FS: never crosses).
   // Returns the number of clocks from DEINT entry to the valid pulse, -1 on timeout.
   task automatic convert(input int n, input bit in_deint, output int lat);
      int cnt;
      bit seen;
      lat = -1;
      if (!in_deint) begin
         if (n == 0) begin
            seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
               tick();
               seen = (ch_vm === 1'b1);
            end
            if (!seen) begin
               tests++; fails++;
               $display("FAIL convert_wait_int: ch_vm=%b required 1", ch_vm);
               return;
            end
            cmp = 1'b1;
         end
         seen = 1'b0;
         for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = (ch_ref === 1'b1);
         end
         if (!seen) begin
            tests++; fails++;
            $display("FAIL convert_wait_deint: ch_ref=%b required 1", ch_ref);
            cmp = 1'b0;
            return;
         end
      end
      cnt = 0;
      if (n >= 2 && n < FS) begin
         repeat (n - 2) tick();
         cnt = n - 2;
         cmp = 1'b1;
      end
      seen = 1'b0;
      for (int i = 0; i < 150 && !seen; i++) begin
         tick();
         cnt++;
         seen = (valid === 1'b1);
      end
      cmp = 1'b0;
      if (!seen) begin
         tests++; fails++;
         $display("FAIL convert_wait_valid: valid=%b required 1", valid);
         return;
      end
      lat = cnt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      enb  = 1'b0;
      cmp  = 1'b1;
      hold = 1'b1;
      do_reset();
      tests++;
      if ({ch_zr, ch_vm, ch_ref} !== 3'b100) begin
         fails++; $display("FAIL reset_switches: got %b required 100", {ch_zr, ch_vm, ch_ref});
      end
      tests++;
      if (bcd_out !== 8'h00) begin
         fails++; $display("FAIL reset_bcd: got %h required 00", bcd_out);
      end
      tests++;
      if (seg_out !== 14'h3F7E) begin
         fails++; $display("FAIL reset_seg: got %h required 3f7e", seg_out);
      end
      tests++;
      if (ovr !== 1'b0 || valid !== 1'b0) begin
         fails++; $display("FAIL reset_flags: ovr=%b valid=%b required 0 0", ovr, valid);
      end
      enb  = 1'b1;
      cmp  = 1'b0;
      hold = 1'b0;
   endtask

   task automatic test_phase_timing();
      int n_az;
      int n_int;
      int bad;
      n_az  = 0;
      n_int = 0;
      bad   = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         n_az++;
         if ((32'(ch_zr) + 32'(ch_vm) + 32'(ch_ref)) != 1) bad++;
         if (ch_vm === 1'b1) break;
      end
      for (int i = 0; i < 300; i++) begin
         tick();
         n_int++;
         if ((32'(ch_zr) + 32'(ch_vm) + 32'(ch_ref)) != 1) bad++;
         if (ch_ref === 1'b1) break;
      end
      tests++;
      if (n_az != FS) begin
         fails++; $display("FAIL phase_az_len: got %0d clocks required %0d", n_az, FS);
      end
      tests++;
      if (n_int != FS) begin
         fails++; $display("FAIL phase_int_len: got %0d clocks required %0d", n_int, FS);
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL phase_onehot: got %0d violations required 0", bad);
      end
   endtask

   task automatic test_reading(input int n, input bit in_deint, input string tag);
      int  lat;
      int  exp_lat;
      int  val;
      bit  ov;
      ov      = (n >= FS);
      val     = ov ? FS - 1 : n;
      exp_lat = ov ? FS : n + 1;
      convert(n, in_deint, lat);
      tests++;
      if (lat != exp_lat) begin
         fails++; $display("FAIL %s_latency: got %0d required %0d", tag, lat, exp_lat);
      end
      tests++;
      if (bcd_out !== exp_bcd(val)) begin
         fails++; $display("FAIL %s_bcd: got %h required %h", tag, bcd_out, exp_bcd(val));
      end
      tests++;
      if (seg_out !== exp_seg(val, ov)) begin
         fails++; $display("FAIL %s_seg: got %h required %h", tag, seg_out, exp_seg(val, ov));
      end
      tests++;
      if (ovr !== ov) begin
         fails++; $display("FAIL %s_ovr: got %b required %b", tag, ovr, ov);
      end
      tests++;
      if ({ch_zr, ch_vm, ch_ref} !== 3'b100) begin
         fails++; $display("FAIL %s_to_az: got %b required 100", tag, {ch_zr, ch_vm, ch_ref});
      end
      tick();
      tests++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL %s_valid_width: got %b required 0", tag, valid);
      end
   endtask

   task automatic test_random_readings();
      for (int i = 0; i < 6; i++) begin
         test_reading(int'($urandom_range(2, FS - 2)), 1'b0, "random");
      end
   endtask

   task automatic test_enb_pause();
      int  p;
      int  n_int;
      bit  seen;
      p    = int'($urandom_range(5, 20));
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         tick();
         seen = (ch_vm === 1'b1);
      end
      n_int = 0;
      repeat (20) begin tick(); n_int++; end
      enb = 1'b0;
      repeat (p) begin tick(); n_int++; end
      enb  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         n_int++;
         seen = (ch_ref === 1'b1);
      end
      tests++;
      if (n_int != FS + p) begin
         fails++; $display("FAIL enb_pause_int_len: got %0d clocks required %0d", n_int, FS + p);
      end
      test_reading(42, 1'b1, "pause");
   endtask

   task automatic test_enb_freeze();
      int  j;
      int  bad;
      bit  seen;
      j    = int'($urandom_range(5, 50));
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         tick();
         seen = (ch_ref === 1'b1);
      end
      repeat (j) tick();
      enb = 1'b0;
      cmp = 1'b1;
      bad = 0;
      repeat (8) begin
         tick();
         if (valid !== 1'b0 || ch_ref !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL freeze_no_exit: got %0d bad cycles required 0", bad);
      end
      enb = 1'b1;
      tick();
      cmp = 1'b0;
      tests++;
      if (valid !== 1'b1) begin
         fails++; $display("FAIL freeze_resume_valid: got %b required 1", valid);
      end
      tests++;
      if (bcd_out !== exp_bcd(j)) begin
         fails++; $display("FAIL freeze_reading: got %h required %h", bcd_out, exp_bcd(j));
      end
      tick();
   endtask

   task automatic test_hold();
      int a;
      int b;
      int lat;
      a = int'($urandom_range(10, 49));
      b = int'($urandom_range(50, 90));
      test_reading(a, 1'b0, "pre_hold");
      hold = 1'b1;
      convert(b, 1'b0, lat);
      tests++;
      if (lat != b + 1) begin
         fails++; $display("FAIL hold_valid: got latency %0d required %0d", lat, b + 1);
      end
      tests++;
      if (bcd_out !== exp_bcd(a) || seg_out !== exp_seg(a, 1'b0)) begin
         fails++; $display("FAIL hold_display: got %h/%h required %h/%h",
                           bcd_out, seg_out, exp_bcd(a), exp_seg(a, 1'b0));
      end
      convert(FS, 1'b0, lat);
      tests++;
      if (lat != FS || ovr !== 1'b0 || bcd_out !== exp_bcd(a)) begin
         fails++; $display("FAIL hold_overrange: got lat=%0d ovr=%b bcd=%h required %0d 0 %h",
                           lat, ovr, bcd_out, FS, exp_bcd(a));
      end
      hold = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit seen;
      int bad;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         tick();
         seen = (ch_ref === 1'b1);
      end
      repeat (5) tick();
      cmp = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmp = 1'b0;
      tests++;
      if (valid !== 1'b0 || {ch_zr, ch_vm, ch_ref} !== 3'b100) begin
         fails++; $display("FAIL reset_mid_state: got valid=%b sw=%b required 0 100",
                           valid, {ch_zr, ch_vm, ch_ref});
      end
      tests++;
      if (bcd_out !== 8'h00 || seg_out !== 14'h3F7E || ovr !== 1'b0) begin
         fails++; $display("FAIL reset_mid_display: got %h/%h/%b required 00/3f7e/0",
                           bcd_out, seg_out, ovr);
      end
      bad = 0;
      repeat (20) begin
         tick();
         if (valid !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL reset_mid_no_valid: got %0d pulses required 0", bad);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      enb  = 1'b0;
      cmp  = 1'b0;
      hold = 1'b0;
      test_reset();
      test_phase_timing();
      test_reading(FS, 1'b1, "overrange");
      test_reading(42, 1'b0, "reading42");
      test_random_readings();
      test_reading(0, 1'b0, "zero");
      test_reading(FS - 1, 1'b0, "cmp_at_max");
      test_enb_pause();
      test_enb_freeze();
      test_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
